// File: rtl/acc_store_pkg.sv
// acc_store_pkg: shared state encoding and default sizing for the accumulator store port.
package acc_store_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_TIMEOUT_CYC = 15;

endpackage

// File: rtl/acc_store_timer.sv
// acc_store_timer: counts ack-wait cycles; expired_o flags the cycle that reaches LIMIT.
module acc_store_timer
    import acc_store_pkg::*;
#(
    parameter int LIMIT = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        cnt_q <= '0;
        else if (clr_i)  cnt_q <= '0;
        else if (en_i)   cnt_q <= cnt_q + CW'(1);
    end

    // cnt_q holds completed wait cycles, so the LIMIT-th one is the current cycle
    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/acc_store_unit.sv
// acc_store_unit: captures ACC and address on start, writes them to memory via req/ack.
// Optional ack-wait timeout enabled by defining ACC_STORE_TIMEOUT_EN.
module acc_store_unit
    import acc_store_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] acc_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              err_clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              cap, timeout;

`ifdef ACC_STORE_TIMEOUT_EN
    acc_store_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q != REQ),
        .en_i      (mem_req & ~mem_ack),
        .expired_o (timeout)
    );
`else
    logic timeout_unused;
    assign timeout_unused = |TIMEOUT_CYC;
    assign timeout        = 1'b0;
`endif

    // A start in DONE chains straight into the next store; in REQ it is an overrun
    assign cap     = start && (state_q != REQ);
    assign state_d = cap ? REQ :
                     (state_q == REQ) ? (mem_ack ? DONE : (timeout ? IDLE : REQ)) : IDLE;
    assign addr_d  = cap ? addr : addr_q;
    assign wdata_d = cap ? acc_data : wdata_q;
    assign err_d   = (start && state_q == REQ) || timeout || (err_q && !err_clr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_acc_store_unit.sv
// tb_acc_store_unit: directed stores with a queue-based scoreboard checked by a monitor.
module tb_acc_store_unit;

    localparam int DW = 16;
    localparam int AW = 12;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            n;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] acc_data = '0;
    logic          err_clr = 1'b0;
    logic          mem_ack = 1'b0;
    logic          busy, done, err, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int   checks = 0;
    int   failures = 0;
    int   req_cnt = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    acc_store_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .acc_data(acc_data),
        .busy(busy), .done(done), .err(err), .err_clr(err_clr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks every REQ cycle against the head of the queue, pops on done
    always @(negedge clk) begin
        if (!rst) begin
            req_cnt = 0;
        end else begin
            check("we_eq_req", mem_we, mem_req);
            if (mem_req) begin
                req_cnt++;
                if (q.size() == 0) check("req_unexpected", 1, 0);
                else begin
                    check("req_addr", mem_addr, q[0].a);
                    check("req_wdata", mem_wdata, q[0].d);
                end
            end
            if (done) begin
                if (q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    check("req_cycles", req_cnt, q[0].n);
                    void'(q.pop_front());
                end
                req_cnt = 0;
            end else if (!mem_req) begin
                req_cnt = 0;
            end
        end
    end

    // Issue one store; ack arrives after w wait cycles; optional overrun start in first REQ cycle
    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input int w, input bit ovr);
        q.push_back('{a: a, d: d, n: w + 1});
        start = 1'b1; addr = a; acc_data = d;
        @(posedge clk); #1;
        start = 1'b0; acc_data = 16'hFFFF; addr = ~a;
        for (int i = 0; i <= w; i++) begin
            mem_ack = (i == w);
            if (ovr && i == 0) start = 1'b1;
            @(negedge clk);
            check("req_hold", mem_req, 1);
            @(posedge clk); #1;
            start = 1'b0; mem_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); addr = AW'($urandom); acc_data = DW'($urandom);
            mem_ack = 1'($urandom); err_clr = 1'($urandom);
            @(negedge clk);
            check("reset_outs", {busy, done, err, mem_req, mem_we, mem_addr, mem_wdata}, '0);
        end
        start = 0; mem_ack = 0; err_clr = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_reset", {busy, done, err, mem_req}, '0);
        @(posedge clk); #1;

        store(12'h0A5, 16'h1F00, 0, 0);
        @(negedge clk);
        check("done_imm", done, 1);
        check("err_clean", err, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        store(12'h123, 16'h5A5A, 3, 0);
        store(12'h7FF, 16'h1FFF, 1, 1);
        @(negedge clk);
        check("err_overrun", err, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_sticky", {err, busy}, 2'b10);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", err, 0);

        @(posedge clk); #1;
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        check("ack_idle_ignored", {busy, mem_req, done}, 3'b000);

        @(posedge clk); #1;
        q.push_back('{a: 12'h3C3, d: 16'hBEEF, n: 0});
        start = 1'b1; addr = 12'h3C3; acc_data = 16'hBEEF;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("midrst_req", mem_req, 1);
        #1 rst = 1'b0;
        #1 check("midrst_drop", {mem_req, busy, done}, 3'b000);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_no_done", {done, busy}, 2'b00);

`ifdef ACC_STORE_TIMEOUT_EN
        @(posedge clk); #1;
        q.push_back('{a: 12'h456, d: 16'h0F0F, n: 0});
        start = 1'b1; addr = 12'h456; acc_data = 16'h0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_req", mem_req, 1);
        end
        @(negedge clk);
        check("to_abort", {mem_req, done, err, busy}, 4'b0010);
        q.delete();
`endif

        repeat (2) @(posedge clk);
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_store_unit.md
# acc_store_unit

Memory write-back port for the accumulator in the multicycle datapath. On a one-cycle `start` from the control FSM, it captures the current ACC value and target address, then drives a single write transaction to data memory over a req/ack handshake. It reports completion with a one-cycle `done` pulse. It is the read side of the accumulator: ACC is written by the datapath, and this block reads it out to memory.

## Interface
Parameters:
- DATA_W, 16, accumulator/memory word width
- ADDR_W, 12, data-memory address width (IR operand field)
- TIMEOUT_CYC, 15, max cycles to wait for `mem_ack`; used only when ACC_STORE_TIMEOUT_EN is defined

Ports:
- clk  in  1  single clock, rising-edge active
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  store request from control FSM, single-cycle pulse
- addr  in  ADDR_W  store address, sampled with `start`
- acc_data  in  DATA_W  ACC output, sampled with `start`
- busy  out  1  high while a store is in flight (states REQ and DONE)
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag: start-while-busy overrun, or timeout
- err_clr  in  1  synchronous clear of `err`
- mem_req  out  1  memory write request
- mem_we  out  1  write enable; equals `mem_req`
- mem_addr  out  ADDR_W  captured address
- mem_wdata  out  DATA_W  captured ACC value
- mem_ack  in  1  memory accept; valid only while `mem_req` = 1

## Operation
- States: IDLE, REQ, DONE.
- IDLE
  - `start` = 1 at a rising edge: capture `addr` into `mem_addr` and `acc_data` into `mem_wdata`; go to REQ.
  - Otherwise stay in IDLE.
- REQ
  - `mem_req` = `mem_we` = 1.
  - `mem_ack` = 1 at an edge: go to DONE.
  - Otherwise stay in REQ. The captured address and data stay stable.
- DONE
  - `done` = 1 for exactly this cycle.
  - `start` = 1: capture new operands and go to REQ (back-to-back store).
  - Otherwise go to IDLE.
- `start` while in REQ: the request is ignored and `err` is set. The in-flight transaction is unaffected.
- `mem_ack` outside REQ is ignored.
- `err_clr` and a new error source in the same cycle: the set wins.
- `mem_addr` and `mem_wdata` hold their last captured value until the next capture.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `mem_req`, `mem_we` = 0; `mem_addr` = 0; `mem_wdata` = 0.
- Reset mid-transaction forces `mem_req` low immediately (asynchronous), with no `done`.
- All outputs are registered or decoded from the state register only. There is no combinational path from `mem_ack` to any output.
- Latency with `start` sampled at edge k:
  - `mem_req` high from k to k+1.
  - With ack at k+1: `done` high from k+1 to k+2.
  - Minimum 2 cycles from start to done.
  - Each additional ack-wait cycle adds 1 cycle.
- Peak throughput: one store per 2 cycles, using a DONE → REQ chain.

## Configuration
- Macro: ACC_STORE_TIMEOUT_EN.
- Defined:
  - A wait counter resets on entry to REQ and increments each REQ cycle without ack.
  - On reaching TIMEOUT_CYC, the block sets `err`, drops `mem_req`, and goes to IDLE with no `done`.
  - An ack in the same cycle the limit is reached counts as success.
- Undefined:
  - No counter; REQ waits indefinitely.
  - `err` is set only by overrun.

## Structure
- Shared package `acc_store_pkg` holds:
  - the state enum (IDLE, REQ, DONE)
  - default width constants DATA_W = 16, ADDR_W = 12
  - the default TIMEOUT_CYC value
- Sub-module `acc_store_timer` holds the wait counter. It has a clear input, an enable input, and a `expired` output. It is instantiated only under ACC_STORE_TIMEOUT_EN.

## Test plan
- Reset check: hold `rst` = 0 and drive random inputs → all outputs remain 0. Release `rst` → state IDLE.
- Immediate ack: `start` with addr = 0x0A5, acc_data = 0x1F00, and ack on the first REQ cycle → `mem_req` high for 1 cycle with mem_addr = 0x0A5, mem_wdata = 0x1F00; `done` the following cycle.
- Delayed ack: ack 3 cycles late → `mem_req` held for 4 cycles with stable addr/data. `acc_data` changing to 0xFFFF meanwhile does not alter `mem_wdata`. `done` asserts once.
- Back-to-back and overrun:
  - `start` in DONE with acc_data = 0x1FFF → new REQ with no IDLE gap.
  - `start` during REQ → `err` = 1 and the transaction completes normally.
  - `err_clr` → `err` = 0.
- Reset mid-REQ: pull `rst` low → `mem_req` drops in the same cycle and no `done` is produced.
- Timeout (ACC_STORE_TIMEOUT_EN defined, TIMEOUT_CYC = 4): no ack → `mem_req` drops after 4 REQ cycles, `err` = 1, no `done`, state IDLE.
